reservation_station_n: RTL and testbench

Parametrised successor to the single-ALU reservation station. It holds up to DEPTH decoded instructions waiting on ROB-tagged operands and snoops NUM_WB generic writeback/wakeup ports (CDB, LS-CDB, ROB and RF messages). Each cycle it issues the oldest fully ready entry to the ALU. It sits between InstFetcher dispatch and the ALU, and flushes on `_clear`.

---
 rtl/rs_pkg.sv | 33 +++
 rtl/rs_age_matrix.sv | 38 +++
 rtl/reservation_station_n.sv | 194 +++++++++++++++++++
 tb/tb_reservation_station_n.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Types and constants shared by the reservation station and the ALU.
package rs_pkg;

    localparam int RS_TAG_W  = 5;
    localparam int RS_XLEN   = 32;
    localparam int RS_TYPE_W = 5;

    typedef enum logic [RS_TYPE_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLL  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9
    } alu_op_e;

    typedef struct packed {
        logic [RS_TYPE_W-1:0] op;
        logic [RS_TAG_W-1:0]  rob;
        logic [RS_XLEN-1:0]   v1;
        logic [RS_XLEN-1:0]   v2;
        logic [RS_XLEN-1:0]   imm;
        logic                 d1;
        logic                 d2;
        logic [RS_TAG_W-1:0]  t1;
        logic [RS_TAG_W-1:0]  t2;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_matrix.sv
// Relative-age tracker: grants the oldest requesting entry, one-hot.
module rs_age_matrix #(
    parameter int DEPTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             i_en,
    input  logic [DEPTH-1:0] i_alloc,
    input  logic [DEPTH-1:0] i_free,
    input  logic [DEPTH-1:0] i_req,
    output logic [DEPTH-1:0] o_grant
);

    // r_older[i][j] = 1 means entry i was allocated before entry j
    logic [DEPTH-1:0] r_older [DEPTH];

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
        end else if (i_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (i_alloc[i] || i_free[i]) r_older[i][j] <= 1'b0;
                    else if (i_alloc[j])          r_older[i][j] <= 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_col
        logic [DEPTH-1:0] w_col;
        for (genvar gj = 0; gj < DEPTH; gj++) begin : g_row
            assign w_col[gj] = r_older[gj][gi];
        end
        assign o_grant[gi] = i_req[gi] & ~|(i_req & w_col);
    end

endmodule

// File: rtl/reservation_station_n.sv
// ALU reservation station: holds tagged instructions, snoops wakeup ports,
// issues the oldest fully ready entry each cycle.
module reservation_station_n
    import rs_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = RS_TAG_W,
    parameter int XLEN   = RS_XLEN,
    parameter int TYPE_W = RS_TYPE_W,
    parameter int NUM_WB = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     _clear,
    input  logic                     _rs_ready,
    input  logic [TYPE_W-1:0]        _rs_type,
    input  logic [TAG_W-1:0]         _rs_rob_id,
    input  logic [XLEN-1:0]          _rs_r1,
    input  logic [XLEN-1:0]          _rs_r2,
    input  logic [XLEN-1:0]          _rs_imm,
    input  logic                     _rs_has_dep1,
    input  logic                     _rs_has_dep2,
    input  logic [TAG_W-1:0]         _rs_dep1,
    input  logic [TAG_W-1:0]         _rs_dep2,
    output logic                     _rs_full,
    input  logic [NUM_WB-1:0]        _wb_ready,
    input  logic [NUM_WB*TAG_W-1:0]  _wb_rob_id,
    input  logic [NUM_WB*XLEN-1:0]   _wb_value,
    input  logic                     _alu_full,
    output logic                     _alu_ready,
    output logic [TYPE_W-1:0]        _alu_type,
    output logic [TAG_W-1:0]         _alu_rob_id,
    output logic [XLEN-1:0]          _alu_r1,
    output logic [XLEN-1:0]          _alu_r2,
    output logic [XLEN-1:0]          _alu_imm
);

    typedef struct packed {
        logic [TYPE_W-1:0] op;
        logic [TAG_W-1:0]  rob;
        logic [XLEN-1:0]   v1;
        logic [XLEN-1:0]   v2;
        logic [XLEN-1:0]   imm;
        logic              d1;
        logic              d2;
        logic [TAG_W-1:0]  t1;
        logic [TAG_W-1:0]  t2;
    } entry_t;

    // Returns {hit, value}; scanning downward lets the lowest port win.
    function automatic logic [XLEN:0] wb_match(
        input logic [NUM_WB-1:0]       rdy,
        input logic [NUM_WB*TAG_W-1:0] tags,
        input logic [NUM_WB*XLEN-1:0]  vals,
        input logic [TAG_W-1:0]        tag
    );
        logic [XLEN:0] res;
        res = '0;
        for (int k = NUM_WB - 1; k >= 0; k--) begin
            if (rdy[k] && tags[k*TAG_W +: TAG_W] == tag) res = {1'b1, vals[k*XLEN +: XLEN]};
        end
        return res;
    endfunction

    logic [DEPTH-1:0] r_valid;
    entry_t           r_ent [DEPTH];
    entry_t           w_upd [DEPTH];
    entry_t           w_new;
    entry_t           w_sel;
    logic [DEPTH-1:0] w_ready, w_grant, w_alloc, w_age_alloc, w_age_free;
    logic [XLEN:0]    w_byp1, w_byp2;
    logic             w_dispatch, w_issue;

    logic              r_alu_ready;
    logic [TYPE_W-1:0] r_alu_type;
    logic [TAG_W-1:0]  r_alu_rob_id;
    logic [XLEN-1:0]   r_alu_r1, r_alu_r2, r_alu_imm;

    assign _rs_full   = &r_valid;
    assign w_dispatch = _rs_ready & ~_rs_full;
    assign w_issue    = |w_grant;

    always_comb begin
        w_alloc = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_alloc    = '0;
                w_alloc[i] = 1'b1;
            end
        end
    end

    assign w_byp1 = wb_match(_wb_ready, _wb_rob_id, _wb_value, _rs_dep1);
    assign w_byp2 = wb_match(_wb_ready, _wb_rob_id, _wb_value, _rs_dep2);

    always_comb begin
        w_new = '{op: _rs_type, rob: _rs_rob_id, v1: _rs_r1, v2: _rs_r2, imm: _rs_imm,
                  d1: _rs_has_dep1, d2: _rs_has_dep2, t1: _rs_dep1, t2: _rs_dep2};
        if (_rs_has_dep1 && w_byp1[XLEN]) begin
            w_new.d1 = 1'b0;
            w_new.v1 = w_byp1[XLEN-1:0];
        end
        if (_rs_has_dep2 && w_byp2[XLEN]) begin
            w_new.d2 = 1'b0;
            w_new.v2 = w_byp2[XLEN-1:0];
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
        logic [XLEN:0] w_m1, w_m2;
        entry_t        w_nx;
        assign w_m1 = wb_match(_wb_ready, _wb_rob_id, _wb_value, r_ent[gi].t1);
        assign w_m2 = wb_match(_wb_ready, _wb_rob_id, _wb_value, r_ent[gi].t2);
        always_comb begin
            w_nx = r_ent[gi];
            if (r_ent[gi].d1 && w_m1[XLEN]) begin
                w_nx.d1 = 1'b0;
                w_nx.v1 = w_m1[XLEN-1:0];
            end
            if (r_ent[gi].d2 && w_m2[XLEN]) begin
                w_nx.d2 = 1'b0;
                w_nx.v2 = w_m2[XLEN-1:0];
            end
        end
        assign w_upd[gi]   = w_nx;
        assign w_ready[gi] = r_valid[gi] & ~r_ent[gi].d1 & ~r_ent[gi].d2;
    end

    assign w_age_alloc = (w_dispatch && !_clear) ? w_alloc : '0;
    assign w_age_free  = _clear ? '1 : w_grant;

    rs_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_en    (rdy_in),
        .i_alloc (w_age_alloc),
        .i_free  (w_age_free),
        .i_req   (w_ready & {DEPTH{~_alu_full}}),
        .o_grant (w_grant)
    );

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) w_sel = r_ent[i];
        end
    end

    // Entry payload needs no reset: it is only observed through r_valid.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_valid      <= '0;
            r_alu_ready  <= 1'b0;
            r_alu_type   <= '0;
            r_alu_rob_id <= '0;
            r_alu_r1     <= '0;
            r_alu_r2     <= '0;
            r_alu_imm    <= '0;
        end else if (rdy_in) begin
            if (_clear) begin
                r_valid     <= '0;
                r_alu_ready <= 1'b0;
            end else begin
                r_alu_ready <= w_issue;
                if (w_issue) begin
                    r_alu_type   <= w_sel.op;
                    r_alu_rob_id <= w_sel.rob;
                    r_alu_r1     <= w_sel.v1;
                    r_alu_r2     <= w_sel.v2;
                    r_alu_imm    <= w_sel.imm;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_grant[i]) begin
                        r_valid[i] <= 1'b0;
                    end else if (w_dispatch && w_alloc[i]) begin
                        r_valid[i] <= 1'b1;
                        r_ent[i]   <= w_new;
                    end else if (r_valid[i]) begin
                        r_ent[i]   <= w_upd[i];
                    end
                end
            end
        end
    end

    assign _alu_ready  = r_alu_ready;
    assign _alu_type   = r_alu_type;
    assign _alu_rob_id = r_alu_rob_id;
    assign _alu_r1     = r_alu_r1;
    assign _alu_r2     = r_alu_r2;
    assign _alu_imm    = r_alu_imm;

endmodule

// File: tb/tb_reservation_station_n.sv
// Directed-vector bench for reservation_station_n with hand-computed expectations.
module tb_reservation_station_n;

    localparam int DEPTH = 8, TAG_W = 5, XLEN = 32, TYPE_W = 5, NUM_WB = 4;

    logic                    clk_in = 1'b0;
    logic                    rst_in, rdy_in, tb_clear, rs_ready, has_dep1, has_dep2;
    logic [TYPE_W-1:0]       rs_type;
    logic [TAG_W-1:0]        rs_rob_id, rs_dep1, rs_dep2;
    logic [XLEN-1:0]         rs_r1, rs_r2, rs_imm;
    logic                    rs_full;
    logic [NUM_WB-1:0]       wb_ready;
    logic [NUM_WB*TAG_W-1:0] wb_rob_id;
    logic [NUM_WB*XLEN-1:0]  wb_value;
    logic                    alu_full, alu_ready;
    logic [TYPE_W-1:0]       alu_type;
    logic [TAG_W-1:0]        alu_rob_id;
    logic [XLEN-1:0]         alu_r1, alu_r2, alu_imm;

    int n_checks = 0;
    int n_errors = 0;

    reservation_station_n #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .TYPE_W(TYPE_W), .NUM_WB(NUM_WB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(tb_clear),
        ._rs_ready(rs_ready), ._rs_type(rs_type), ._rs_rob_id(rs_rob_id),
        ._rs_r1(rs_r1), ._rs_r2(rs_r2), ._rs_imm(rs_imm),
        ._rs_has_dep1(has_dep1), ._rs_has_dep2(has_dep2),
        ._rs_dep1(rs_dep1), ._rs_dep2(rs_dep2), ._rs_full(rs_full),
        ._wb_ready(wb_ready), ._wb_rob_id(wb_rob_id), ._wb_value(wb_value),
        ._alu_full(alu_full), ._alu_ready(alu_ready), ._alu_type(alu_type),
        ._alu_rob_id(alu_rob_id), ._alu_r1(alu_r1), ._alu_r2(alu_r2), ._alu_imm(alu_imm)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; tb_clear = 1'b0; rs_ready = 1'b0;
        rs_type = '0; rs_rob_id = '0; rs_r1 = '0; rs_r2 = '0; rs_imm = '0;
        has_dep1 = 1'b0; has_dep2 = 1'b0; rs_dep1 = '0; rs_dep2 = '0;
        wb_ready = '0; wb_rob_id = '0; wb_value = '0; alu_full = 1'b0;
    endtask

    task automatic dispatch(input logic [TYPE_W-1:0] t, input logic [TAG_W-1:0] rob,
                            input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                            input logic [XLEN-1:0] imm,
                            input logic hd1, input logic [TAG_W-1:0] d1,
                            input logic hd2, input logic [TAG_W-1:0] d2);
        rs_ready = 1'b1; rs_type = t; rs_rob_id = rob; rs_r1 = r1; rs_r2 = r2; rs_imm = imm;
        has_dep1 = hd1; rs_dep1 = d1; has_dep2 = hd2; rs_dep2 = d2;
    endtask

    task automatic no_dispatch();
        rs_ready = 1'b0; has_dep1 = 1'b0; has_dep2 = 1'b0;
    endtask

    task automatic wake(input int port, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
        wb_ready[port] = 1'b1;
        wb_rob_id[port*TAG_W +: TAG_W] = tag;
        wb_value[port*XLEN +: XLEN] = val;
    endtask

    initial begin
        int pulses;
        idle_inputs();
        rst_in = 1'b0;

        // Reset and idle
        tick(); tick();
        check("rst_alu_ready", 64'(alu_ready), 64'd0);
        check("rst_alu_type", 64'(alu_type), 64'd0);
        check("rst_alu_rob", 64'(alu_rob_id), 64'd0);
        check("rst_alu_r1", 64'(alu_r1), 64'd0);
        check("rst_alu_r2", 64'(alu_r2), 64'd0);
        check("rst_alu_imm", 64'(alu_imm), 64'd0);
        check("rst_full", 64'(rs_full), 64'd0);
        rst_in = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (alu_ready) pulses++;
        end
        check("idle_no_issue", 64'(pulses), 64'd0);

        // Ready dispatch: issue visible two edges later, one cycle wide
        dispatch(5'd3, 5'd7, 32'd5, 32'd9, 32'h11, 1'b0, '0, 1'b0, '0);
        tick(); no_dispatch();
        check("ready_c1_no_issue", 64'(alu_ready), 64'd0);
        tick();
        check("ready_issue", 64'(alu_ready), 64'd1);
        check("ready_type", 64'(alu_type), 64'd3);
        check("ready_rob", 64'(alu_rob_id), 64'd7);
        check("ready_r1", 64'(alu_r1), 64'd5);
        check("ready_r2", 64'(alu_r2), 64'd9);
        check("ready_imm", 64'(alu_imm), 64'h11);
        tick();
        check("ready_pulse_end", 64'(alu_ready), 64'd0);

        // Dispatch bypass then late wakeup on port 3
        dispatch(5'd1, 5'd2, 32'd0, 32'd3, 32'd0, 1'b1, 5'd4, 1'b0, '0);
        wake(1, 5'd4, 32'hAA);
        tick(); wb_ready = '0;
        dispatch(5'd2, 5'd9, 32'd1, 32'd0, 32'd0, 1'b0, '0, 1'b1, 5'd6);
        tick(); no_dispatch();
        check("byp_issue", 64'(alu_ready), 64'd1);
        check("byp_rob", 64'(alu_rob_id), 64'd2);
        check("byp_r1", 64'(alu_r1), 64'hAA);
        check("byp_r2", 64'(alu_r2), 64'd3);
        tick();
        check("wait_dep2_no_issue", 64'(alu_ready), 64'd0);
        wake(3, 5'd6, 32'h66);
        tick(); wb_ready = '0;
        check("wake_capture_no_issue", 64'(alu_ready), 64'd0);
        tick();
        check("wake_issue", 64'(alu_ready), 64'd1);
        check("wake_rob", 64'(alu_rob_id), 64'd9);
        check("wake_r1", 64'(alu_r1), 64'd1);
        check("wake_r2", 64'(alu_r2), 64'h66);
        tick();

        // Oldest-first: fill all entries waiting on tag 20
        pulses = 0;
        for (int k = 0; k < DEPTH; k++) begin
            dispatch(5'd0, 5'(k), 32'd0, 32'(100 + k), 32'd0, 1'b1, 5'd20, 1'b0, '0);
            tick();
            if (alu_ready) pulses++;
        end
        no_dispatch();
        check("fill_no_issue", 64'(pulses), 64'd0);
        check("fill_full", 64'(rs_full), 64'd1);
        wake(0, 5'd20, 32'h20);
        tick(); wb_ready = '0;
        check("order_full_before_issue", 64'(rs_full), 64'd1);
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            check($sformatf("order_ready_%0d", k), 64'(alu_ready), 64'd1);
            check($sformatf("order_rob_%0d", k), 64'(alu_rob_id), 64'(k));
            check($sformatf("order_r2_%0d", k), 64'(alu_r2), 64'(100 + k));
            if (k == 0) check("order_full_drop", 64'(rs_full), 64'd0);
        end
        check("order_r1", 64'(alu_r1), 64'h20);
        tick();
        check("order_done", 64'(alu_ready), 64'd0);

        // Backpressure and pause
        alu_full = 1'b1;
        dispatch(5'd4, 5'd10, 32'd10, 32'd0, 32'd0, 1'b0, '0, 1'b0, '0);
        tick();
        dispatch(5'd4, 5'd11, 32'd11, 32'd0, 32'd0, 1'b0, '0, 1'b0, '0);
        tick();
        check("bp_c2", 64'(alu_ready), 64'd0);
        dispatch(5'd4, 5'd12, 32'd0, 32'd0, 32'd0, 1'b1, 5'd9, 1'b0, '0);
        tick(); no_dispatch();
        check("bp_c3", 64'(alu_ready), 64'd0);
        tick();
        check("bp_c4", 64'(alu_ready), 64'd0);
        alu_full = 1'b0; rdy_in = 1'b0;
        wake(2, 5'd9, 32'h99);
        tick();
        check("pause_c1", 64'(alu_ready), 64'd0);
        tick();
        check("pause_c2", 64'(alu_ready), 64'd0);
        rdy_in = 1'b1; wb_ready = '0;
        tick();
        check("resume_issue", 64'(alu_ready), 64'd1);
        check("resume_rob_a", 64'(alu_rob_id), 64'd10);
        tick();
        check("resume_rob_b", 64'(alu_rob_id), 64'd11);
        tick();
        check("pause_wake_dropped", 64'(alu_ready), 64'd0);
        wake(2, 5'd9, 32'h99);
        tick(); wb_ready = '0;
        tick();
        check("late_wake_issue", 64'(alu_ready), 64'd1);
        check("late_wake_rob", 64'(alu_rob_id), 64'd12);
        check("late_wake_r1", 64'(alu_r1), 64'h99);
        tick();

        // Flush beats dispatch and issue
        alu_full = 1'b1;
        dispatch(5'd5, 5'd13, 32'd13, 32'd0, 32'd0, 1'b0, '0, 1'b0, '0);
        tick();
        alu_full = 1'b0; tb_clear = 1'b1;
        dispatch(5'd5, 5'd14, 32'd14, 32'd0, 32'd0, 1'b0, '0, 1'b1, 5'd15);
        tick(); tb_clear = 1'b0; no_dispatch();
        check("flush_no_issue", 64'(alu_ready), 64'd0);
        check("flush_not_full", 64'(rs_full), 64'd0);
        wake(0, 5'd15, 32'h15);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick(); wb_ready = '0;
            if (alu_ready) pulses++;
        end
        check("flush_wake_no_issue", 64'(pulses), 64'd0);
        dispatch(5'd6, 5'd16, 32'd16, 32'd0, 32'd0, 1'b0, '0, 1'b0, '0);
        tick(); no_dispatch();
        tick();
        check("post_flush_issue", 64'(alu_ready), 64'd1);
        check("post_flush_rob", 64'(alu_rob_id), 64'd16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
